// File: rtl/operand_collector.sv
// rtl/operand_collector.sv - collects two BCD operands from a keypad stream; optional sign keys under OPERAND_SIGN_EN
module operand_collector #(
    parameter int MAX_DIGITS = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef OPERAND_SIGN_EN
    output logic        num1_neg,
    output logic        num2_neg,
`endif
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic        key_ready,
    input  logic        out_ready,
    output logic        pair_valid,
    output logic [15:0] num1,
    output logic [15:0] num2,
    output logic [1:0]  phase,
    output logic [2:0]  digit_count,
    output logic        err
);

    typedef enum logic [1:0] {
        LOAD1 = 2'd1,
        LOAD2 = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0] KEY_ENTER = 4'hA;
    localparam logic [3:0] KEY_CLEAR = 4'hB;
    localparam logic [3:0] KEY_SIGN  = 4'hC;

    state_t      state, state_nxt;
    logic [15:0] num1_nxt, num2_nxt, cur, cur_nxt;
    logic [2:0]  count_nxt;
    logic        pair_valid_nxt, err_nxt, accept;
    logic        neg_cur, neg_cur_nxt;
    logic        neg1_q, neg2_q, neg1_nxt, neg2_nxt;

    assign key_ready = !rst && (state != HOLD);
    assign accept    = key_valid && key_ready;

    always_comb begin
        state_nxt      = state;
        num1_nxt       = num1;
        num2_nxt       = num2;
        count_nxt      = digit_count;
        pair_valid_nxt = pair_valid;
        err_nxt        = err;
        neg1_nxt       = neg1_q;
        neg2_nxt       = neg2_q;
        cur            = (state == LOAD1) ? num1 : num2;
        neg_cur        = (state == LOAD1) ? neg1_q : neg2_q;
        cur_nxt        = cur;
        neg_cur_nxt    = neg_cur;

        if (state == HOLD) begin
            if (pair_valid && out_ready) begin
                state_nxt      = LOAD1;
                num1_nxt       = '0;
                num2_nxt       = '0;
                count_nxt      = '0;
                pair_valid_nxt = 1'b0;
                err_nxt        = 1'b0;
                neg1_nxt       = 1'b0;
                neg2_nxt       = 1'b0;
            end
        end else if (accept) begin
            if (key_code <= 4'd9) begin
                // Overflowing digits are dropped but flagged until the next clear.
                if (digit_count < 3'(MAX_DIGITS)) begin
                    cur_nxt   = {cur[11:0], key_code};
                    count_nxt = digit_count + 3'd1;
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (key_code == KEY_ENTER) begin
                if (digit_count != 3'd0) begin
                    if (state == LOAD1) begin
                        state_nxt = LOAD2;
                        count_nxt = '0;
                    end else begin
                        state_nxt      = HOLD;
                        pair_valid_nxt = 1'b1;
                    end
                end
            end else if (key_code == KEY_CLEAR) begin
                cur_nxt     = '0;
                count_nxt   = '0;
                err_nxt     = 1'b0;
                neg_cur_nxt = 1'b0;
            end else if (key_code == KEY_SIGN) begin
`ifdef OPERAND_SIGN_EN
                neg_cur_nxt = !neg_cur;
`endif
            end

            if (state == LOAD1) begin
                num1_nxt = cur_nxt;
                neg1_nxt = neg_cur_nxt;
            end else begin
                num2_nxt = cur_nxt;
                neg2_nxt = neg_cur_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD1;
            num1        <= '0;
            num2        <= '0;
            digit_count <= '0;
            pair_valid  <= 1'b0;
            err         <= 1'b0;
            phase       <= 2'd0;
            neg1_q      <= 1'b0;
            neg2_q      <= 1'b0;
        end else begin
            state       <= state_nxt;
            num1        <= num1_nxt;
            num2        <= num2_nxt;
            digit_count <= count_nxt;
            pair_valid  <= pair_valid_nxt;
            err         <= err_nxt;
            // phase tracks the state being entered so it never lags a transition.
            phase       <= state_nxt;
            neg1_q      <= neg1_nxt;
            neg2_q      <= neg2_nxt;
        end
    end

`ifdef OPERAND_SIGN_EN
    assign num1_neg = neg1_q;
    assign num2_neg = neg2_q;
`else
    logic unused_neg;
    assign unused_neg = neg1_q ^ neg2_q;
`endif

endmodule

// File: tb/tb_operand_collector.sv
// tb/tb_operand_collector.sv - self-checking bench for operand_collector with a decimal reference model
module tb_operand_collector;

    logic        clk = 1'b0;
    logic        rst, key_valid, key_ready, out_ready, pair_valid, err;
    logic [3:0]  key_code;
    logic [15:0] num1, num2;
    logic [1:0]  phase;
    logic [2:0]  digit_count;
`ifdef OPERAND_SIGN_EN
    logic        num1_neg, num2_neg;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: operands as decimal integers, state as 1/2/3.
    int m_state = 1;
    int m_phase = 0;
    int m_val[2];
    int m_neg[2];
    int m_cnt = 0;
    int m_err = 0;
    int m_pv  = 0;

    always #5 clk = ~clk;

    operand_collector #(.MAX_DIGITS(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef OPERAND_SIGN_EN
        .num1_neg(num1_neg),
        .num2_neg(num2_neg),
`endif
        .key_valid(key_valid),
        .key_code(key_code),
        .key_ready(key_ready),
        .out_ready(out_ready),
        .pair_valid(pair_valid),
        .num1(num1),
        .num2(num2),
        .phase(phase),
        .digit_count(digit_count),
        .err(err)
    );

    function automatic logic [15:0] bcd(input int v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic v, input logic [3:0] c, input logic o, input logic r);
        int k;
        if (r) begin
            m_state = 1; m_phase = 0; m_cnt = 0; m_err = 0; m_pv = 0;
            m_val[0] = 0; m_val[1] = 0; m_neg[0] = 0; m_neg[1] = 0;
            return;
        end
        if (m_state == 3) begin
            if (o) begin
                m_state = 1; m_cnt = 0; m_err = 0; m_pv = 0;
                m_val[0] = 0; m_val[1] = 0; m_neg[0] = 0; m_neg[1] = 0;
            end
        end else if (v) begin
            k = m_state - 1;
            if (c < 10) begin
                if (m_cnt < 4) begin
                    m_val[k] = m_val[k] * 10 + int'(c);
                    m_cnt++;
                end else m_err = 1;
            end else if (c == 4'hA) begin
                if (m_cnt > 0) begin
                    if (m_state == 1) begin m_state = 2; m_cnt = 0; end
                    else begin m_state = 3; m_pv = 1; end
                end
            end else if (c == 4'hB) begin
                m_val[k] = 0; m_cnt = 0; m_err = 0; m_neg[k] = 0;
            end else if (c == 4'hC) begin
`ifdef OPERAND_SIGN_EN
                m_neg[k] = 1 - m_neg[k];
`endif
            end
        end
        m_phase = m_state;
    endtask

    task automatic compare_all();
        check("num1", 32'(num1), 32'(bcd(m_val[0])));
        check("num2", 32'(num2), 32'(bcd(m_val[1])));
        check("pair_valid", 32'(pair_valid), 32'(m_pv));
        check("phase", 32'(phase), 32'(m_phase));
        check("digit_count", 32'(digit_count), 32'(m_cnt));
        check("err", 32'(err), 32'(m_err));
`ifdef OPERAND_SIGN_EN
        check("num1_neg", 32'(num1_neg), 32'(m_neg[0]));
        check("num2_neg", 32'(num2_neg), 32'(m_neg[1]));
`endif
    endtask

    task automatic cyc(input logic v, input logic [3:0] c, input logic o, input logic r);
        rst = r; key_valid = v; key_code = c; out_ready = o;
        #1;
        check("key_ready", 32'(key_ready), 32'(!r && m_state != 3));
        model_step(v, c, o, r);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic key(input logic [3:0] c);
        cyc(1'b1, c, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic o);
        cyc(1'b0, 4'h0, o, 1'b0);
    endtask

    initial begin
        logic [3:0] rc;
        m_val[0] = 0; m_val[1] = 0; m_neg[0] = 0; m_neg[1] = 0;
        rst = 1'b1; key_valid = 1'b0; key_code = 4'h0; out_ready = 1'b0;

        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_num1", 32'(num1), 32'h0);
        idle(1'b0);
        check("phase_after_reset", 32'(phase), 32'd1);

        key(4'h1); key(4'h2); key(4'hA); key(4'h3); key(4'hA);
        check("pair_num1", 32'(num1), 32'h0012);
        check("pair_num2", 32'(num2), 32'h0003);
        check("pair_valid_set", 32'(pair_valid), 32'd1);
        check("pair_phase", 32'(phase), 32'd3);
        check("hold_key_ready", 32'(key_ready), 32'd0);

        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 4'h7, 1'b0, 1'b0);
            check("hold_num1", 32'(num1), 32'h0012);
            check("hold_num2", 32'(num2), 32'h0003);
        end
        idle(1'b1);
        check("release_phase", 32'(phase), 32'd1);
        check("release_num1", 32'(num1), 32'h0);
        check("release_num2", 32'(num2), 32'h0);

        key(4'h9); key(4'h8); key(4'h7); key(4'h6); key(4'h5);
        check("ovf_num1", 32'(num1), 32'h9876);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_count", 32'(digit_count), 32'd4);
        key(4'hB);
        check("clear_err", 32'(err), 32'd0);
        check("clear_num1", 32'(num1), 32'h0);

        key(4'hA);
        check("empty_enter_phase", 32'(phase), 32'd1);
        key(4'hB);
        key(4'h4);
        check("digit4_phase", 32'(phase), 32'd1);
        key(4'hA);
        check("enter_phase", 32'(phase), 32'd2);
        check("enter_num1", 32'(num1), 32'h0004);
        key(4'h1); key(4'hA); idle(1'b1);

        key(4'h5); key(4'hA); key(4'h7);
        cyc(1'b0, 4'h0, 1'b0, 1'b1);
        check("midrst_phase", 32'(phase), 32'd0);
        check("midrst_num1", 32'(num1), 32'h0);
        check("midrst_num2", 32'(num2), 32'h0);
        idle(1'b0);
        check("midrst_phase1", 32'(phase), 32'd1);
        key(4'h2);
        check("midrst_num1_2", 32'(num1), 32'h0002);
        key(4'hB);

`ifdef OPERAND_SIGN_EN
        key(4'h3); key(4'hC); key(4'hA); key(4'hC); key(4'hC); key(4'h4); key(4'hA);
        check("sign_num1_neg", 32'(num1_neg), 32'd1);
        check("sign_num2_neg", 32'(num2_neg), 32'd0);
        check("sign_num1", 32'(num1), 32'h0003);
        check("sign_num2", 32'(num2), 32'h0004);
        idle(1'b1);
`endif

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 1) == 1) rc = 4'($urandom_range(0, 9));
            else rc = 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), rc, 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 59) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
